// File: rtl/exe_mem_reg.sv
// EXE->MEM pipeline register: 2-entry skid buffer with valid/ready handshake and NZCV status register.
// Optional stall counter enabled by defining EXE_MEM_PERF_EN.
module exe_mem_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [3:0]        alu_status,
    input  logic              s_bit,
    input  logic              wb_en,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [DEST_W-1:0] dest,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_alu_res,
    output logic [DATA_W-1:0] out_val_rm,
    output logic              out_wb_en,
    output logic              out_mem_r_en,
    output logic              out_mem_w_en,
    output logic [DEST_W-1:0] out_dest,
    output logic [3:0]        sr_out
`ifdef EXE_MEM_PERF_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0] aluRes;
        logic [DATA_W-1:0] valRm;
        logic [DEST_W-1:0] dest;
        logic              wbEn;
        logic              memREn;
        logic              memWEn;
        logic              sBit;
        logic [3:0]        status;
    } entry_t;

    entry_t     r_head;
    entry_t     r_skid;
    logic       r_hv;
    logic       r_kv;
    logic [3:0] r_sr;

    entry_t     w_inEntry;
    logic       w_accept;
    logic       w_handoff;

    always_comb begin
        w_inEntry        = '0;
        w_inEntry.aluRes = alu_res;
        w_inEntry.valRm  = val_rm;
        w_inEntry.dest   = dest;
        w_inEntry.wbEn   = wb_en;
        w_inEntry.memREn = mem_r_en;
        w_inEntry.memWEn = mem_w_en;
        w_inEntry.sBit   = s_bit;
        w_inEntry.status = alu_status;
    end

    // in_ready comes straight from the skid-valid flop, so upstream never sees out_ready combinationally.
    assign w_accept  = in_valid & ~r_kv & ~flush;
    assign w_handoff = r_hv & out_ready & ~flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head <= '0;
            r_skid <= '0;
            r_hv   <= 1'b0;
            r_kv   <= 1'b0;
            r_sr   <= 4'b0000;
        end else if (flush) begin
            r_hv <= 1'b0;
            r_kv <= 1'b0;
        end else begin
            if (w_handoff && r_head.sBit) begin
                r_sr <= r_head.status;
            end
            if (w_handoff) begin
                if (r_kv) begin
                    r_head <= r_skid;
                    r_kv   <= 1'b0;
                end else if (w_accept) begin
                    r_head <= w_inEntry;
                end else begin
                    r_hv <= 1'b0;
                end
            end else if (w_accept) begin
                if (!r_hv) begin
                    r_head <= w_inEntry;
                    r_hv   <= 1'b1;
                end else begin
                    r_skid <= w_inEntry;
                    r_kv   <= 1'b1;
                end
            end
        end
    end

    assign in_ready     = ~r_kv;
    assign out_valid    = r_hv;
    assign out_alu_res  = r_head.aluRes;
    assign out_val_rm   = r_head.valRm;
    assign out_wb_en    = r_head.wbEn;
    assign out_mem_r_en = r_head.memREn;
    assign out_mem_w_en = r_head.memWEn;
    assign out_dest     = r_head.dest;
    assign sr_out       = r_sr;

`ifdef EXE_MEM_PERF_EN
    logic [31:0] r_stallCnt;

    // Saturating count of cycles where MEM holds off a valid head; flush does not clear it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stallCnt <= 32'd0;
        end else if (r_hv && !out_ready && !flush && (r_stallCnt != 32'hFFFF_FFFF)) begin
            r_stallCnt <= r_stallCnt + 32'd1;
        end
    end

    assign stall_cnt = r_stallCnt;
`endif

endmodule

// File: tb/tb_exe_mem_reg.sv
// Directed self-checking bench for exe_mem_reg; checks stall_cnt when EXE_MEM_PERF_EN is defined.
module tb_exe_mem_reg;

    logic        clk;
    logic        rst;
    logic        inValid;
    logic        inReady;
    logic [31:0] aluRes;
    logic [3:0]  aluStatus;
    logic        sBit;
    logic        wbEn;
    logic        memREn;
    logic        memWEn;
    logic [31:0] valRm;
    logic [3:0]  dest;
    logic        flush;
    logic        outValid;
    logic        outReady;
    logic [31:0] outAluRes;
    logic [31:0] outValRm;
    logic        outWbEn;
    logic        outMemREn;
    logic        outMemWEn;
    logic [3:0]  outDest;
    logic [3:0]  srOut;
`ifdef EXE_MEM_PERF_EN
    logic [31:0] stallCnt;
`endif

    int checkCount = 0;
    int errorCount = 0;

    exe_mem_reg #(.DATA_W(32), .DEST_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (inValid),
        .in_ready     (inReady),
        .alu_res      (aluRes),
        .alu_status   (aluStatus),
        .s_bit        (sBit),
        .wb_en        (wbEn),
        .mem_r_en     (memREn),
        .mem_w_en     (memWEn),
        .val_rm       (valRm),
        .dest         (dest),
        .flush        (flush),
        .out_valid    (outValid),
        .out_ready    (outReady),
        .out_alu_res  (outAluRes),
        .out_val_rm   (outValRm),
        .out_wb_en    (outWbEn),
        .out_mem_r_en (outMemREn),
        .out_mem_w_en (outMemWEn),
        .out_dest     (outDest),
        .sr_out       (srOut)
`ifdef EXE_MEM_PERF_EN
        ,
        .stall_cnt    (stallCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Side fields are derived from the result so every bundle is distinguishable.
    task automatic applyStimulus(input logic valid, input logic [31:0] res, input logic [3:0] status,
                                 input logic s, input logic ready, input logic fl);
        inValid   = valid;
        aluRes    = res;
        aluStatus = status;
        sBit      = s;
        valRm     = res ^ 32'hA5A5_0000;
        dest      = res[3:0];
        wbEn      = res[0];
        memREn    = res[1];
        memWEn    = res[2];
        outReady  = ready;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
        #2;
        checkOutput("rst_out_valid", {31'd0, outValid}, 32'd0);
        checkOutput("rst_in_ready", {31'd0, inReady}, 32'd1);
        checkOutput("rst_sr", {28'd0, srOut}, 32'd0);
        checkOutput("rst_alu_res", outAluRes, 32'd0);
        checkOutput("rst_dest", {28'd0, outDest}, 32'd0);
        #10;
        rst = 1'b1;
        tick();

        // Single S-flagged bundle.
        applyStimulus(1'b1, 32'h0000_0005, 4'b0010, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("single_valid", {31'd0, outValid}, 32'd1);
        checkOutput("single_res", outAluRes, 32'h0000_0005);
        checkOutput("single_valrm", outValRm, 32'hA5A5_0005);
        checkOutput("single_dest", {28'd0, outDest}, 32'd5);
        checkOutput("single_ctrl", {29'd0, outWbEn, outMemREn, outMemWEn}, 32'b101);
        checkOutput("single_sr_pre", {28'd0, srOut}, 32'd0);
        checkOutput("single_in_ready", {31'd0, inReady}, 32'd1);
        applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("single_sr_post", {28'd0, srOut}, 32'b0010);
        checkOutput("single_drained", {31'd0, outValid}, 32'd0);
        checkOutput("single_in_ready2", {31'd0, inReady}, 32'd1);

        // Back-to-back stream with MEM always ready.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h0000_0100 + i, 4'b1111, 1'b0, 1'b1, 1'b0);
            tick();
            checkOutput($sformatf("stream_valid%0d", i), {31'd0, outValid}, 32'd1);
            checkOutput($sformatf("stream_res%0d", i), outAluRes, 32'h0000_0100 + i);
            checkOutput($sformatf("stream_ready%0d", i), {31'd0, inReady}, 32'd1);
        end
        applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("stream_end", {31'd0, outValid}, 32'd0);
        checkOutput("stream_sr", {28'd0, srOut}, 32'b0010);

        // Stall: A to head, B to skid, C held upstream, then drain in order.
        applyStimulus(1'b1, 32'h0000_00A1, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("stall_a_res", outAluRes, 32'h0000_00A1);
        checkOutput("stall_a_ready", {31'd0, inReady}, 32'd1);
        applyStimulus(1'b1, 32'h0000_00B2, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("stall_b_head", outAluRes, 32'h0000_00A1);
        checkOutput("stall_b_ready", {31'd0, inReady}, 32'd0);
        applyStimulus(1'b1, 32'h0000_00C3, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("stall_c_head", outAluRes, 32'h0000_00A1);
        checkOutput("stall_c_ready", {31'd0, inReady}, 32'd0);
        applyStimulus(1'b1, 32'h0000_00C3, 4'b0000, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("drain_b_valid", {31'd0, outValid}, 32'd1);
        checkOutput("drain_b_res", outAluRes, 32'h0000_00B2);
        checkOutput("drain_b_ready", {31'd0, inReady}, 32'd1);
        tick();
        checkOutput("drain_c_res", outAluRes, 32'h0000_00C3);
        checkOutput("drain_c_dest", {28'd0, outDest}, 32'd3);
        applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("drain_empty", {31'd0, outValid}, 32'd0);
        checkOutput("drain_hold_res", outAluRes, 32'h0000_00C3);

        // Status register only follows S-flagged handoffs.
        applyStimulus(1'b1, 32'h0000_0011, 4'b1000, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("sflag_pre", {28'd0, srOut}, 32'b0010);
        applyStimulus(1'b1, 32'h0000_0022, 4'b0100, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("sflag_a", {28'd0, srOut}, 32'b1000);
        applyStimulus(1'b1, 32'h0000_0033, 4'b0001, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("sflag_b", {28'd0, srOut}, 32'b1000);
        applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("sflag_c", {28'd0, srOut}, 32'b0001);

        // Flush a full buffer with an S-flagged head while MEM is ready.
        applyStimulus(1'b1, 32'h0000_00D4, 4'b1111, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h0000_00E5, 4'b0110, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("flush_full", {31'd0, inReady}, 32'd0);
        applyStimulus(1'b1, 32'h0000_00F6, 4'b1010, 1'b1, 1'b1, 1'b1);
        tick();
        checkOutput("flush_valid", {31'd0, outValid}, 32'd0);
        checkOutput("flush_ready", {31'd0, inReady}, 32'd1);
        checkOutput("flush_sr", {28'd0, srOut}, 32'b0001);
        applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("flush_no_ghost", {31'd0, outValid}, 32'd0);
        checkOutput("flush_sr2", {28'd0, srOut}, 32'b0001);

        // Asynchronous reset mid-cycle with both entries held.
        applyStimulus(1'b1, 32'h0000_0077, 4'b1100, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h0000_0088, 4'b0011, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("arst_pre_full", {31'd0, inReady}, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("arst_valid", {31'd0, outValid}, 32'd0);
        checkOutput("arst_res", outAluRes, 32'd0);
        checkOutput("arst_sr", {28'd0, srOut}, 32'd0);
        checkOutput("arst_ready", {31'd0, inReady}, 32'd1);
        applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        tick();
        checkOutput("arst_after_ready", {31'd0, inReady}, 32'd1);
        checkOutput("arst_after_valid", {31'd0, outValid}, 32'd0);
`ifdef EXE_MEM_PERF_EN
        checkOutput("perf_reset", stallCnt, 32'd0);
`endif

        // Five-cycle hold of a valid head.
        applyStimulus(1'b1, 32'h0000_0099, 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("hold_res", outAluRes, 32'h0000_0099);
        checkOutput("hold_valid", {31'd0, outValid}, 32'd1);
`ifdef EXE_MEM_PERF_EN
        checkOutput("perf_hold5", stallCnt, 32'd5);
`endif
        applyStimulus(1'b0, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("hold_release", {31'd0, outValid}, 32'd0);
`ifdef EXE_MEM_PERF_EN
        checkOutput("perf_after", stallCnt, 32'd5);
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
